// File: rtl/hilo_pkg.sv
// hilo_pkg: shared constants and types for the HI/LO multiply scheduler.
package hilo_pkg;
    localparam int XLEN = 32;
    localparam logic [3:0] ALU_MULT  = 4'b0110;
    localparam logic [3:0] ALU_MULTU = 4'b0111;
    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic RD_LO = 1'b0;
    localparam logic RD_HI = 1'b1;
    typedef enum logic {IDLE, RUN} state_t;
endpackage

// File: rtl/hilo_sched_if.sv
// hilo_sched_if: execute-stage, ALU and HI/LO access signals (MTHI/MTLO port under HILO_MTHI_MTLO_EN).
interface hilo_sched_if;
    import hilo_pkg::*;
    logic            start;
    logic            start_sgn;
    logic [XLEN-1:0] ex_a;
    logic [XLEN-1:0] ex_b;
    logic [3:0]      ex_op;
    logic [4:0]      ex_shamt;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [3:0]      alu_op;
    logic [4:0]      alu_shamt;
    logic [XLEN-1:0] alu_hi;
    logic [XLEN-1:0] alu_lo;
    logic            rd_req;
    logic            rd_sel;
    logic [XLEN-1:0] rd_data;
    logic            busy;
    logic            stall;
`ifdef HILO_MTHI_MTLO_EN
    logic            wr_en;
    logic            wr_sel;
    logic [XLEN-1:0] wr_data;
`endif
    modport slave (
`ifdef HILO_MTHI_MTLO_EN
        input  wr_en, wr_sel, wr_data,
`endif
        input  start, start_sgn, ex_a, ex_b, ex_op, ex_shamt, alu_hi, alu_lo, rd_req, rd_sel,
        output alu_a, alu_b, alu_op, alu_shamt, rd_data, busy, stall
    );
    modport master (
`ifdef HILO_MTHI_MTLO_EN
        output wr_en, wr_sel, wr_data,
`endif
        output start, start_sgn, ex_a, ex_b, ex_op, ex_shamt, alu_hi, alu_lo, rd_req, rd_sel,
        input  alu_a, alu_b, alu_op, alu_shamt, rd_data, busy, stall
    );
endinterface

// File: rtl/hilo_regs.sv
// hilo_regs: architectural HI/LO registers with product capture, direct write and read select.
module hilo_regs
    import hilo_pkg::*;
#(
    parameter int WIDTH = XLEN
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             capture,
    input  logic [WIDTH-1:0] cap_hi,
    input  logic [WIDTH-1:0] cap_lo,
    input  logic             wr_en,
    input  logic             wr_sel,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_sel,
    output logic [WIDTH-1:0] rd_data
);
    logic [WIDTH-1:0] hi, lo;
    // Product capture overwrites both halves; a direct write touches only the selected one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi <= '0;
            lo <= '0;
        end else if (capture) begin
            hi <= cap_hi;
            lo <= cap_lo;
        end else if (wr_en) begin
            if (wr_sel == RD_HI) hi <= wr_data;
            else lo <= wr_data;
        end
    end
    assign rd_data = (rd_sel == RD_HI) ? hi : lo;
endmodule

// File: rtl/hilo_sched.sv
// hilo_sched: shares the execute ALU with MULT/MULTU, owns HI/LO and stalls the pipe on hazards.
// Optional MTHI/MTLO write port enabled by defining HILO_MTHI_MTLO_EN.
module hilo_sched
    import hilo_pkg::*;
#(
    parameter int MUL_LAT = 4,
    parameter int WIDTH   = XLEN
) (
    input  logic        clk,
    input  logic        rst_n,
    hilo_sched_if.slave bus
);
    localparam int CW = $clog2(MUL_LAT + 1);
    state_t           state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [WIDTH-1:0] op_a, op_b;
    logic             op_sgn, run, accept, capture, wr_en, wr_sel;
    logic [WIDTH-1:0] wr_data;
`ifdef HILO_MTHI_MTLO_EN
    assign wr_en   = bus.wr_en;
    assign wr_sel  = bus.wr_sel;
    assign wr_data = bus.wr_data;
`else
    assign wr_en   = 1'b0;
    assign wr_sel  = RD_LO;
    assign wr_data = '0;
`endif
    assign run     = state == RUN;
    assign accept  = !run && bus.start;
    assign capture = run && cnt == '0;
    // State and countdown registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end
    // A start in IDLE arms the countdown; RUN ends on the cycle the product is captured
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (accept) begin
            state_nxt = RUN;
            cnt_nxt   = CW'(MUL_LAT - 1);
        end else if (run) begin
            state_nxt = capture ? IDLE : RUN;
            cnt_nxt   = capture ? cnt : cnt - CW'(1);
        end
    end
    // Operands are held for the whole multiply so the ALU path can close over several cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a   <= '0;
            op_b   <= '0;
            op_sgn <= 1'b0;
        end else if (accept) begin
            op_a   <= bus.ex_a;
            op_b   <= bus.ex_b;
            op_sgn <= bus.start_sgn;
        end
    end
    assign bus.alu_a     = run ? op_a : bus.ex_a;
    assign bus.alu_b     = run ? op_b : bus.ex_b;
    assign bus.alu_op    = run ? (op_sgn ? ALU_MULT : ALU_MULTU) : bus.ex_op;
    assign bus.alu_shamt = run ? 5'd0 : bus.ex_shamt;
    assign bus.busy      = run;
    assign bus.stall     = run && (bus.start || bus.rd_req || bus.ex_op != ALU_AND || wr_en);
    hilo_regs #(.WIDTH(WIDTH)) u_regs (
        .clk     (clk),
        .rst_n   (rst_n),
        .capture (capture),
        .cap_hi  (bus.alu_hi),
        .cap_lo  (bus.alu_lo),
        .wr_en   (wr_en && !run),
        .wr_sel  (wr_sel),
        .wr_data (wr_data),
        .rd_sel  (bus.rd_sel),
        .rd_data (bus.rd_data)
    );
endmodule
